// File: rtl/fpga_link_pkg.sv
// fpga_link_pkg: shared FPGA-to-FPGA link definitions (state encoding, default frame width, default timeout)
package fpga_link_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACK      = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_WAIT_FIN = 3'd3,
    ST_DONE     = 3'd4
  } link_state_e;
  localparam int LINK_WIDTH   = 8;
  localparam int LINK_TIMEOUT = 255;
endpackage

// File: rtl/fpga_shift_in_register.sv
// fpga_shift_in_register: WIDTH-bit serial-in/parallel-out register, MSB first.
//   clk, reset (async active-low), clr_i (sync clear), en_i (shift enable),
//   d_i (serial bit in), q_o (parallel word out)
module fpga_shift_in_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] shift_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) shift_q <= '0;
    else if (clr_i) shift_q <= '0;
    else if (en_i) shift_q <= {shift_q[WIDTH-2:0], d_i};
  assign q_o = shift_q;
endmodule

// File: rtl/fpga_receiver.sv
// fpga_receiver: serial-to-parallel receiver for the FPGA-to-FPGA link with host valid/read handshake.
//   clk, reset (async active-low)
//   sendToOther/dataIn/finish : request level, MSB-first serial data, end-of-frame from transmitter
//   acknowledge               : grant to transmitter (withheld while an unread word is pending)
//   hostRead, dataOut, dataValid : host side of the assembled word
//   busy                      : any state other than IDLE
//   timeoutErr                : sticky watchdog abort flag, only with FPGA_RX_TIMEOUT_EN, else 0
module fpga_receiver
  import fpga_link_pkg::*;
#(
  parameter int WIDTH = LINK_WIDTH
`ifdef FPGA_RX_TIMEOUT_EN
  , parameter int TIMEOUT = LINK_TIMEOUT
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sendToOther,
  input  logic             dataIn,
  input  logic             finish,
  input  logic             hostRead,
  output logic             acknowledge,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic             busy,
  output logic             timeoutErr
);
  localparam int CW = $clog2(WIDTH) + 1;
  link_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d, shift_w;
  logic             ack_q, ack_d, valid_q, valid_d, complete;
`ifdef FPGA_RX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          tmo_q, tmo_d, tmo_fire;
  assign tmo_fire = (state_q != ST_IDLE) && (wdog_q == WW'(TIMEOUT - 1));
`endif
  fpga_shift_in_register #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == ST_ACK),
    .en_i  (state_q == ST_SHIFT),
    .d_i   (dataIn),
    .q_o   (shift_w)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = (sendToOther && !valid_q) ? ST_ACK : ST_IDLE;
      ST_ACK:      state_d = sendToOther ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:    state_d = !sendToOther ? ST_IDLE : (cnt_q == CW'(WIDTH - 1)) ? ST_WAIT_FIN : ST_SHIFT;
      ST_WAIT_FIN: state_d = !sendToOther ? ST_IDLE : finish ? ST_DONE : ST_WAIT_FIN;
      ST_DONE:     state_d = sendToOther ? ST_DONE : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
`ifdef FPGA_RX_TIMEOUT_EN
    if (tmo_fire) state_d = ST_IDLE;
`endif
    // Completion is derived from the final next state so aborts and timeouts never latch a word.
    complete = (state_q == ST_WAIT_FIN) && (state_d == ST_DONE);
    cnt_d    = (state_q == ST_SHIFT) ? cnt_q + 1'b1 : '0;
    ack_d    = state_d inside {ST_ACK, ST_SHIFT, ST_WAIT_FIN};
    valid_d  = complete || (valid_q && !hostRead);
    data_d   = complete ? shift_w : data_q;
  end
`ifdef FPGA_RX_TIMEOUT_EN
  always_comb begin
    wdog_d = (state_d != state_q || state_q == ST_IDLE) ? '0 : wdog_q + 1'b1;
    tmo_d  = tmo_fire || (tmo_q && !complete);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  assign timeoutErr = tmo_q;
`else
  assign timeoutErr = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  assign acknowledge = ack_q;
  assign dataOut     = data_q;
  assign dataValid   = valid_q;
  assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fpga_receiver.sv
// tb_fpga_receiver: directed table-driven and sequence checks for fpga_receiver
module tb_fpga_receiver;
  logic clk = 1'b0, reset = 1'b0, sendToOther = 1'b0, dataIn = 1'b0, finish = 1'b0, hostRead = 1'b0;
  logic acknowledge, dataValid, busy, timeoutErr;
  logic [7:0] dataOut;
  int chk_cnt = 0, pass_cnt = 0;
  logic [7:0] exp_data = 8'h00;
  logic exp_valid = 1'b0;

  fpga_receiver #(
    .WIDTH(8)
`ifdef FPGA_RX_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .sendToOther(sendToOther), .dataIn(dataIn), .finish(finish),
    .hostRead(hostRead), .acknowledge(acknowledge), .dataOut(dataOut), .dataValid(dataValid),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic send, din, fin, rd;
    logic ack, valid, bsy;
    logic [7:0] data;
  } vec_t;
  vec_t v [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic read_word();
    hostRead = 1'b1;
    tick();
    hostRead = 1'b0;
    exp_valid = 1'b0;
    check("host read clears valid", {31'd0, dataValid}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] w, input int fdelay);
    sendToOther = 1'b1; finish = 1'b0; dataIn = 1'b0;
    tick();
    check($sformatf("ack after req %0h", w), {31'd0, acknowledge}, 32'd1);
    tick();
    for (int i = 7; i >= 0; i--) begin
      dataIn = w[i];
      tick();
    end
    dataIn = 1'b0;
    check($sformatf("data held before finish %0h", w), {23'd0, dataValid, dataOut}, {23'd0, exp_valid, exp_data});
    repeat (fdelay) tick();
    if (fdelay > 0)
      check($sformatf("data held late finish %0h", w), {22'd0, acknowledge, dataValid, dataOut}, {22'd0, 1'b1, exp_valid, exp_data});
    finish = 1'b1;
    tick();
    finish = 1'b0;
    exp_data = w; exp_valid = 1'b1;
    check($sformatf("frame done %0h", w), {21'd0, acknowledge, dataValid, busy, dataOut}, {21'd0, 1'b0, 1'b1, 1'b1, w});
    sendToOther = 1'b0;
    tick();
    check($sformatf("idle after frame %0h", w), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    v[0]  = '{1,0,0,0, 1,0,1, 8'h00};
    v[1]  = '{1,0,0,0, 1,0,1, 8'h00};
    v[2]  = '{1,1,0,0, 1,0,1, 8'h00};
    v[3]  = '{1,0,0,0, 1,0,1, 8'h00};
    v[4]  = '{1,1,0,0, 1,0,1, 8'h00};
    v[5]  = '{1,0,1,0, 1,0,1, 8'h00};
    v[6]  = '{1,0,0,0, 1,0,1, 8'h00};
    v[7]  = '{1,1,0,0, 1,0,1, 8'h00};
    v[8]  = '{1,0,0,0, 1,0,1, 8'h00};
    v[9]  = '{1,1,0,0, 1,0,1, 8'h00};
    v[10] = '{1,0,1,0, 0,1,1, 8'hA5};
    v[11] = '{1,0,0,0, 0,1,1, 8'hA5};
    v[12] = '{0,0,0,0, 0,1,0, 8'hA5};
    v[13] = '{0,0,0,1, 0,0,0, 8'hA5};
    v[14] = '{0,0,0,1, 0,0,0, 8'hA5};
    #3;
    check("reset outputs", {20'd0, acknowledge, dataValid, busy, timeoutErr, dataOut}, 32'd0);
    #9 reset = 1'b1;
    tick();
    check("idle after reset release", {20'd0, acknowledge, dataValid, busy, timeoutErr, dataOut}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      sendToOther = v[i].send; dataIn = v[i].din; finish = v[i].fin; hostRead = v[i].rd;
      tick();
      check($sformatf("vec %0d", i), {21'd0, acknowledge, dataValid, busy, dataOut},
            {21'd0, v[i].ack, v[i].valid, v[i].bsy, v[i].data});
    end
    sendToOther = 1'b0; dataIn = 1'b0; finish = 1'b0; hostRead = 1'b0;
    exp_data = 8'hA5; exp_valid = 1'b0;
    // backpressure
    run_frame(8'h3C, 0);
    sendToOther = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("backpressure hold %0d", i), {30'd0, acknowledge, busy}, 32'd0);
    end
    hostRead = 1'b1;
    tick();
    hostRead = 1'b0;
    exp_valid = 1'b0;
    check("backpressure read", {30'd0, dataValid, acknowledge}, 32'd0);
    run_frame(8'hC3, 0);
    // late finish
    read_word();
    run_frame(8'hFF, 20);
    // transmitter abort after four bits
    read_word();
    sendToOther = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      dataIn = 1'b1;
      tick();
    end
    sendToOther = 1'b0;
    tick();
    check("abort", {21'd0, acknowledge, busy, dataValid, dataOut}, {21'd0, 1'b0, 1'b0, 1'b0, 8'hFF});
    run_frame(8'h81, 0);
    // async reset mid-shift
    read_word();
    sendToOther = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      dataIn = 1'b1;
      tick();
    end
    #3 reset = 1'b0;
    #1;
    check("async reset mid-shift", {20'd0, acknowledge, dataValid, busy, timeoutErr, dataOut}, 32'd0);
    sendToOther = 1'b0; dataIn = 1'b0;
    #2 reset = 1'b1;
    exp_data = 8'h00; exp_valid = 1'b0;
    tick();
    check("idle after mid-frame reset", {31'd0, busy}, 32'd0);
    run_frame(8'h5A, 0);
`ifdef FPGA_RX_TIMEOUT_EN
    read_word();
    sendToOther = 1'b1;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      dataIn = 1'b1;
      tick();
    end
    dataIn = 1'b0;
    repeat (15) tick();
    check("wait_fin before timeout", {30'd0, busy, timeoutErr}, {30'd0, 1'b1, 1'b0});
    tick();
    check("timeout fires", {29'd0, acknowledge, busy, timeoutErr}, {29'd0, 1'b0, 1'b0, 1'b1});
    sendToOther = 1'b0;
    tick();
    check("timeout sticky", {31'd0, timeoutErr}, 32'd1);
    run_frame(8'h69, 0);
    check("timeout cleared by frame", {31'd0, timeoutErr}, 32'd0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
